// File: rtl/voice_pkg.sv
// Shared types and widths for the voice allocator and its target picker.
package voice_pkg;

    localparam int RATE_W = 24;
    localparam int NOTE_W = 7;
    localparam int AGE_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        DECIDE,
        GAP,
        ASSIGN
    } alloc_state_t;

    typedef struct packed {
        logic              on;
        logic [NOTE_W-1:0] note;
        logic [RATE_W-1:0] rate;
        logic [AGE_W-1:0]  age;
    } voice_t;

endpackage

// File: rtl/voice_picker.sv
// Combinational target selection: same-note retrigger, else lowest free voice,
// else the oldest active voice (lowest index wins ties).
module voice_picker
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  voice_t            voices_i [NUM_VOICES],
    input  logic [NOTE_W-1:0] note_i,
    output logic [IDX_W-1:0]  target_o,
    output logic              hit_same_o,
    output logic              hit_free_o,
    output logic              steal_o
);

    logic             same_found;
    logic             free_found;
    logic [IDX_W-1:0] same_idx;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] old_idx;
    logic [AGE_W-1:0] old_age;

    // Rates play no part in the choice.
    logic [NUM_VOICES-1:0] unused_rate;
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_unused
        assign unused_rate[gi] = ^voices_i[gi].rate;
    end

    always_comb begin
        same_found = 1'b0;
        free_found = 1'b0;
        same_idx   = '0;
        free_idx   = '0;
        old_idx    = '0;
        old_age    = voices_i[0].age;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!same_found && voices_i[i].on && voices_i[i].note == note_i) begin
                same_found = 1'b1;
                same_idx   = IDX_W'(i);
            end
            if (!free_found && !voices_i[i].on) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            // Strict compare keeps the lowest index on equal ages.
            if (voices_i[i].age > old_age) begin
                old_age = voices_i[i].age;
                old_idx = IDX_W'(i);
            end
        end
        hit_same_o = same_found;
        hit_free_o = !same_found && free_found;
        steal_o    = !same_found && !free_found;
        if (same_found) begin
            target_o = same_idx;
        end else if (free_found) begin
            target_o = free_idx;
        end else begin
            target_o = old_idx;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note events onto oscillator voices, forcing a
// one-cycle is_on gap whenever a busy voice is re-assigned.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = voice_pkg::NOTE_W,
    parameter int RATE_W     = voice_pkg::RATE_W,
    parameter int AGE_W      = voice_pkg::AGE_W
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         all_off_in,
    input  logic                         ev_valid_in,
    output logic                         ev_ready_out,
    input  logic                         ev_note_on_in,
    input  logic [NOTE_W-1:0]            ev_note_in,
    input  logic [RATE_W-1:0]            ev_rate_in,
    output logic [NUM_VOICES-1:0]        voice_on_out,
    output logic [NUM_VOICES*RATE_W-1:0] voice_rate_out,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note_out,
    output logic                         steal_out
);
    import voice_pkg::voice_t;
    import voice_pkg::alloc_state_t;
    import voice_pkg::IDLE;
    import voice_pkg::DECIDE;
    import voice_pkg::GAP;
    import voice_pkg::ASSIGN;

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    alloc_state_t      state_q;
    voice_t            voices_q [NUM_VOICES];
    logic              ev_on_q;
    logic [NOTE_W-1:0] ev_note_q;
    logic [RATE_W-1:0] ev_rate_q;
    logic [IDX_W-1:0]  target_q;
    logic              steal_q;

    logic [IDX_W-1:0]  pick_idx;
    logic              hit_same;
    logic              hit_free;
    logic              pick_steal;
    logic              do_assign;
    logic [IDX_W-1:0]  assign_idx;

    voice_picker #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_picker (
        .voices_i   (voices_q),
        .note_i     (ev_note_q),
        .target_o   (pick_idx),
        .hit_same_o (hit_same),
        .hit_free_o (hit_free),
        .steal_o    (pick_steal)
    );

    assign ev_ready_out = (state_q == IDLE) && !rst_in && !all_off_in;

    // The write for a busy voice lands when leaving GAP so is_on is low for exactly one cycle.
    assign do_assign  = (state_q == GAP) || (state_q == DECIDE && ev_on_q && hit_free);
    assign assign_idx = (state_q == GAP) ? target_q : pick_idx;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            ev_on_q   <= 1'b0;
            ev_note_q <= '0;
            ev_rate_q <= '0;
            target_q  <= '0;
            steal_q   <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voices_q[i] <= '0;
            end
        end else begin
            steal_q <= 1'b0;
            if (all_off_in) begin
                state_q <= IDLE;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    voices_q[i].on  <= 1'b0;
                    voices_q[i].age <= '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ev_valid_in && ev_ready_out) begin
                            ev_on_q   <= ev_note_on_in;
                            ev_note_q <= ev_note_in;
                            ev_rate_q <= ev_rate_in;
                            state_q   <= DECIDE;
                        end
                    end
                    DECIDE: begin
                        if (!ev_on_q) begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (voices_q[i].on && voices_q[i].note == ev_note_q) begin
                                    voices_q[i].on <= 1'b0;
                                end
                            end
                            state_q <= IDLE;
                        end else if (hit_free) begin
                            state_q <= IDLE;
                        end else begin
                            voices_q[pick_idx].on <= 1'b0;
                            target_q <= pick_idx;
                            steal_q  <= pick_steal;
                            state_q  <= GAP;
                        end
                    end
                    GAP:     state_q <= ASSIGN;
                    ASSIGN:  state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase

                if (do_assign) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (assign_idx == IDX_W'(i)) begin
                            voices_q[i].on   <= 1'b1;
                            voices_q[i].note <= ev_note_q;
                            voices_q[i].rate <= ev_rate_q;
                            voices_q[i].age  <= '0;
                        end else if (voices_q[i].on && voices_q[i].age != AGE_MAX) begin
                            voices_q[i].age <= voices_q[i].age + 1'b1;
                        end
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_out
        assign voice_on_out[gi]                     = voices_q[gi].on;
        assign voice_rate_out[gi*RATE_W +: RATE_W]  = voices_q[gi].rate;
        assign voice_note_out[gi*NOTE_W +: NOTE_W]  = voices_q[gi].note;
    end

    assign steal_out = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator; outputs sampled 1 time unit after each rising edge.
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int NW = 7;
    localparam int RW = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             all_off;
    logic             ev_valid;
    logic             ev_ready;
    logic             ev_note_on;
    logic [NW-1:0]    ev_note;
    logic [RW-1:0]    ev_rate;
    logic [NV-1:0]    voice_on;
    logic [NV*RW-1:0] voice_rate;
    logic [NV*NW-1:0] voice_note;
    logic             steal;

    int checks   = 0;
    int errors   = 0;
    int hs_count = 0;

    always #5 clk = ~clk;

    voice_allocator #(
        .NUM_VOICES (NV),
        .NOTE_W     (NW),
        .RATE_W     (RW),
        .AGE_W      (8)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .all_off_in     (all_off),
        .ev_valid_in    (ev_valid),
        .ev_ready_out   (ev_ready),
        .ev_note_on_in  (ev_note_on),
        .ev_note_in     (ev_note),
        .ev_rate_in     (ev_rate),
        .voice_on_out   (voice_on),
        .voice_rate_out (voice_rate),
        .voice_note_out (voice_note),
        .steal_out      (steal)
    );

    always @(posedge clk) begin
        if (ev_valid && ev_ready) hs_count <= hs_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rate_of(input int i);
        return 32'(voice_rate[i*RW +: RW]);
    endfunction

    function automatic logic [31:0] note_of(input int i);
        return 32'(voice_note[i*NW +: NW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 time unit after the handshake edge (FSM in DECIDE).
    task automatic send(input bit on, input int note, input int rate);
        int n;
        ev_note_on = on;
        ev_note    = NW'(note);
        ev_rate    = RW'(rate);
        ev_valid   = 1'b1;
        n = 0;
        while (!ev_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            check("ready_timeout", 32'(ev_ready), 32'd1);
            ev_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            ev_valid = 1'b0;
            $display("EV on=%0d note=%0d rate=%0d t=%0t", on, note, rate, $time);
        end
    endtask

    initial begin
        int h0;
        int n;
        rst        = 1'b1;
        all_off    = 1'b0;
        ev_valid   = 1'b0;
        ev_note_on = 1'b0;
        ev_note    = '0;
        ev_rate    = '0;
        tick();
        tick();
        check("rst_ready", 32'(ev_ready), 32'd0);
        check("rst_on", 32'(voice_on), 32'd0);
        check("rst_steal", 32'(steal), 32'd0);
        check("rst_rate0", rate_of(0), 32'd0);
        check("rst_note3", note_of(3), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(ev_ready), 32'd1);

        // Free voice assignment
        send(1, 60, 1000);
        check("decide_ready", 32'(ev_ready), 32'd0);
        check("decide_on", 32'(voice_on), 32'd0);
        tick();
        check("free_on", 32'(voice_on), 32'b0001);
        check("free_rate0", rate_of(0), 32'd1000);
        check("free_note0", note_of(0), 32'd60);
        check("free_ready", 32'(ev_ready), 32'd1);

        // Fill the bank, then steal the oldest
        send(1, 62, 2000); tick();
        send(1, 64, 3000); tick();
        send(1, 67, 4000); tick();
        check("fill_on", 32'(voice_on), 32'b1111);
        send(1, 69, 500);
        tick();
        check("steal_gap_on", 32'(voice_on), 32'b1110);
        check("steal_pulse", 32'(steal), 32'd1);
        tick();
        check("steal_on", 32'(voice_on), 32'b1111);
        check("steal_rate0", rate_of(0), 32'd500);
        check("steal_note0", note_of(0), 32'd69);
        check("steal_pulse_end", 32'(steal), 32'd0);
        check("assign_ready", 32'(ev_ready), 32'd0);
        tick();
        check("steal_ready_back", 32'(ev_ready), 32'd1);

        // Retrigger voice 1
        send(1, 62, 800);
        tick();
        check("retrig_gap_on", 32'(voice_on), 32'b1101);
        check("retrig_steal0", 32'(steal), 32'd0);
        tick();
        check("retrig_on", 32'(voice_on), 32'b1111);
        check("retrig_rate1", rate_of(1), 32'd800);
        check("retrig_note1", note_of(1), 32'd62);
        check("retrig_rate0", rate_of(0), 32'd500);
        check("retrig_rate2", rate_of(2), 32'd3000);
        check("retrig_rate3", rate_of(3), 32'd4000);
        check("retrig_steal1", 32'(steal), 32'd0);

        // Note-offs: held and not held
        send(0, 64, 0);
        tick();
        check("off_on", 32'(voice_on), 32'b1011);
        check("off_note_kept", note_of(2), 32'd64);
        send(0, 71, 0);
        tick();
        check("off_miss_on", 32'(voice_on), 32'b1011);
        check("off_miss_ready", 32'(ev_ready), 32'd1);

        // Panic during GAP
        send(1, 62, 900);
        tick();
        check("panic_gap_on", 32'(voice_on), 32'b1001);
        all_off = 1'b1;
        tick();
        check("panic_on", 32'(voice_on), 32'd0);
        check("panic_ready", 32'(ev_ready), 32'd0);
        all_off = 1'b0;
        #1;
        check("panic_idle_ready", 32'(ev_ready), 32'd1);
        repeat (3) tick();
        check("panic_no_assign", 32'(voice_on), 32'd0);
        check("panic_rate1", rate_of(1), 32'd800);
        send(1, 72, 111);
        tick();
        check("after_panic_on", 32'(voice_on), 32'b0001);
        check("after_panic_note0", note_of(0), 32'd72);
        check("after_panic_rate0", rate_of(0), 32'd111);

        // Back-to-back with valid held high
        h0 = hs_count;
        ev_valid   = 1'b1;
        ev_note_on = 1'b1;
        for (int e = 0; e < 3; e++) begin
            ev_note = (e == 0) ? NW'(74) : (e == 1) ? NW'(76) : NW'(77);
            ev_rate = RW'(5000 + e);
            n = 0;
            while (!ev_ready && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) check("b2b_timeout", 32'(ev_ready), 32'd1);
            @(posedge clk);
            #1;
            $display("EV on=1 note=%0d rate=%0d t=%0t", ev_note, ev_rate, $time);
        end
        ev_valid = 1'b0;
        repeat (2) tick();
        check("b2b_count", 32'(hs_count - h0), 32'd3);
        check("b2b_on", 32'(voice_on), 32'b1111);
        check("b2b_note1", note_of(1), 32'd74);
        check("b2b_note2", note_of(2), 32'd76);
        check("b2b_note3", note_of(3), 32'd77);
        check("b2b_rate3", rate_of(3), 32'd5002);

        // Age saturation decides the steal victim
        all_off = 1'b1;
        tick();
        all_off = 1'b0;
        check("sat_clear", 32'(voice_on), 32'd0);
        send(1, 60, 1);
        send(1, 62, 2);
        for (int k = 0; k < 250; k++) send(1, 60, 3);
        send(1, 64, 4);
        send(1, 67, 5);
        for (int k = 0; k < 50; k++) send(1, 60, 6);
        send(1, 71, 7);
        tick();
        check("sat_steal_gap", 32'(voice_on), 32'b1101);
        check("sat_steal_pulse", 32'(steal), 32'd1);
        tick();
        check("sat_steal_on", 32'(voice_on), 32'b1111);
        check("sat_note1", note_of(1), 32'd71);
        check("sat_rate1", rate_of(1), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
